spi_tx_ctrl: RTL

//  Byte-level SPI transmit sequencer for the ILI9341 link; sits directly upstream of the
//  spi_shift MOSI shift register. Accepts command/data bytes over a valid/ready handshake.

---
 rtl/spi_tx_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/spi_tx_ctrl.sv
// Byte-level SPI transmit sequencer feeding the spi_shift MOSI register.
// Streams back-to-back bytes under one CS frame, then holds CS high for CS_GAP.
module spi_tx_ctrl #(
  parameter int DW     = 8,
  parameter int CS_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid,
  input  logic          tx_dc,
  input  logic [DW-1:0] tx_data,
  output logic          tx_ready,
  output logic          sh_load,
  output logic          sh_shift_en,
  output logic [DW-1:0] sh_data,
  output logic          sck_en,
  output logic          cs_n,
  output logic          dc,
  output logic          busy
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;
  logic          sck_en_q, sck_en_d;
  logic          last_bit;

  assign last_bit    = (bit_cnt_q == CW'(DW - 1));
  assign tx_ready    = rst & ((state_q == IDLE) |
                              ((state_q == SHIFT) & last_bit));
  assign sh_load     = tx_valid & tx_ready;
  assign sh_shift_en = (state_q == SHIFT) & ~last_bit;
  assign sh_data     = tx_data;
  assign sck_en      = sck_en_q;
  assign cs_n        = cs_n_q;
  assign dc          = dc_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    cs_n_d    = cs_n_q;
    dc_d      = dc_q;
    sck_en_d  = sck_en_q;
    unique case (state_q)
      IDLE: begin
        if (sh_load) begin
          dc_d      = tx_dc;
          cs_n_d    = 1'b0;
          sck_en_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else if (tx_valid) begin
          // gapless chaining: next byte loads on the last-bit cycle
          dc_d      = tx_dc;
          bit_cnt_d = '0;
        end else begin
          cs_n_d    = 1'b1;
          sck_en_d  = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(CS_GAP - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cs_n_d   = 1'b1;
        sck_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      sck_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      dc_q      <= dc_d;
      sck_en_q  <= sck_en_d;
    end
  end

endmodule
